// File: rtl/test_pkg.sv
// Shared constants and helpers for the test-harness blocks.
// Widths derived per instance live in the modules themselves.
package test_pkg;

    localparam int MAX_CH = 8;

    // $clog2 returns 0 for 1, which would give a zero-width vector.
    function automatic int clog2_min1(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/id_fifo.sv
// In-order FIFO of channel IDs for issued transfers.
// Storage is registered and the head is read combinationally.
module id_fifo
    import test_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 1,
    localparam int AW    = clog2_min1(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout_head,
    output logic [AW:0]      o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // The extra pointer bit tells full from empty when the low bits match.
    assign o_count     = r_wr_ptr - r_rd_ptr;
    assign o_empty     = (r_wr_ptr == r_rd_ptr);
    assign o_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push   = i_push && !o_full;
    assign w_do_pop    = i_pop && !o_empty;
    assign o_dout_head = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

endmodule

// File: rtl/dut_share_arbiter.sv
// Shares one in-order DUT between several test channels: round-robin issue
// into a registered stage, responses routed back by an in-order ID FIFO.
module dut_share_arbiter
    import test_pkg::*;
#(
    parameter  int WORD_SIZE       = 16,
    parameter  int NUM_WORDS       = 1,
    parameter  int NUM_CH          = 2,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int W               = NUM_WORDS * WORD_SIZE,
    localparam int CHW             = clog2_min1(NUM_CH),
    localparam int CW              = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic [NUM_CH-1:0]   req_valid_i,
    output logic [NUM_CH-1:0]   req_ready_o,
    input  logic [NUM_CH*W-1:0] req_data_i,
    output logic [NUM_CH-1:0]   rsp_valid_o,
    input  logic [NUM_CH-1:0]   rsp_ready_i,
    output logic [W-1:0]        rsp_data_o,
    output logic                dut_valid_o,
    input  logic                dut_ready_i,
    output logic [W-1:0]        dut_data_o,
    input  logic                dut_valid_i,
    output logic                dut_ready_o,
    input  logic [W-1:0]        dut_data_i,
    output logic [CW-1:0]       outstanding_o,
    output logic                err_o
);

    if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("dut_share_arbiter: NUM_CH out of range");
    end
    if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_depth
        $error("dut_share_arbiter: MAX_OUTSTANDING must be a power of 2, at least 2");
    end

    logic              r_dut_valid;
    logic [W-1:0]      r_dut_data;
    logic [CHW-1:0]    r_rr;
    logic              r_err;

    logic              w_slot_free;
    logic              w_can_issue;
    logic              w_found;
    logic              w_grant;
    logic [NUM_CH-1:0] w_grant_oh;
    logic [CHW-1:0]    w_grant_id;
    logic [W-1:0]      w_grant_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;
    logic [CHW-1:0]    w_head;
    logic [CW-1:0]     w_count;

    assign w_slot_free = !r_dut_valid || dut_ready_i;
    assign w_can_issue = w_slot_free && !w_fifo_full;
    assign w_grant     = w_found && w_can_issue && reset_n_i;
    assign req_ready_o = w_grant ? w_grant_oh : '0;

    // Search from the rr pointer upward with wrap; constant indices keep selects static.
    always_comb begin
        w_found      = 1'b0;
        w_grant_oh   = '0;
        w_grant_id   = '0;
        w_grant_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!w_found && req_valid_i[c] && (c == (int'(r_rr) + k) % NUM_CH)) begin
                    w_found       = 1'b1;
                    w_grant_oh[c] = 1'b1;
                    w_grant_id    = CHW'(c);
                    w_grant_data  = req_data_i[c*W +: W];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_dut_valid <= 1'b0;
            r_dut_data  <= '0;
            r_rr        <= '0;
        end else if (w_grant) begin
            r_dut_valid <= 1'b1;
            r_dut_data  <= w_grant_data;
            r_rr        <= (w_grant_id == CHW'(NUM_CH - 1)) ? '0 : w_grant_id + 1'b1;
        end else if (w_slot_free) begin
            r_dut_valid <= 1'b0;
        end
    end

    // Only the FIFO head may see the DUT output, so a stalled head blocks everyone.
    always_comb begin
        rsp_valid_o = '0;
        dut_ready_o = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!w_fifo_empty && (w_head == CHW'(c))) begin
                rsp_valid_o[c] = dut_valid_i;
                dut_ready_o    = rsp_ready_i[c];
            end
        end
    end

    assign w_pop      = dut_valid_i && dut_ready_o;
    assign rsp_data_o = dut_data_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_err <= 1'b0;
        end else if (dut_valid_i && w_fifo_empty) begin
            r_err <= 1'b1;
        end
    end

    id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (CHW)
    ) u_id_fifo (
        .i_clk       (clk_i),
        .i_rst_n     (reset_n_i),
        .i_push      (w_grant),
        .i_pop       (w_pop),
        .i_din       (w_grant_id),
        .o_dout_head (w_head),
        .o_count     (w_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign dut_valid_o   = r_dut_valid;
    assign dut_data_o    = r_dut_data;
    assign outstanding_o = w_count;
    assign err_o         = r_err;

endmodule

// File: tb/tb_dut_share_arbiter.sv
// Directed scoreboard bench for dut_share_arbiter with a 2-cycle identity DUT model.
module tb_dut_share_arbiter;

    localparam int NCH = 2;
    localparam int WD  = 16;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            resetN = 1'b1;
    logic [NCH-1:0]  reqValid = '0;
    logic [NCH-1:0]  reqReady;
    logic [NCH*WD-1:0] reqData = '0;
    logic [NCH-1:0]  rspValid;
    logic [NCH-1:0]  rspReady = '1;
    logic [WD-1:0]   rspData;
    logic            dutValidOut;
    logic            dutReadyIn = 1'b1;
    logic [WD-1:0]   dutDataOut;
    logic            dutValidIn;
    logic            dutReadyOut;
    logic [WD-1:0]   dutDataIn;
    logic [2:0]      outstanding;
    logic            errFlag;

    logic [31:0]     expQ[$];
    logic [31:0]     obsQ[$];
    int              checks = 0;
    int              failures = 0;

    logic [WD-1:0]   mQ[$];
    int              mT[$];
    int              mCycle = 0;
    logic            mValid = 1'b0;
    logic [WD-1:0]   mData = '0;
    logic            mOutEn = 1'b1;
    logic            tbForce = 1'b0;
    logic            peakClear = 1'b1;
    logic [2:0]      peakOut = '0;

    assign dutValidIn = mValid | tbForce;
    assign dutDataIn  = mData;

    always #5 clk = ~clk;

    dut_share_arbiter dut (
        .clk_i         (clk),
        .reset_n_i     (resetN),
        .req_valid_i   (reqValid),
        .req_ready_o   (reqReady),
        .req_data_i    (reqData),
        .rsp_valid_o   (rspValid),
        .rsp_ready_i   (rspReady),
        .rsp_data_o    (rspData),
        .dut_valid_o   (dutValidOut),
        .dut_ready_i   (dutReadyIn),
        .dut_data_o    (dutDataOut),
        .dut_valid_i   (dutValidIn),
        .dut_ready_o   (dutReadyOut),
        .dut_data_i    (dutDataIn),
        .outstanding_o (outstanding),
        .err_o         (errFlag)
    );

    // In-order identity DUT: an accepted word is presented LAT edges later.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mQ.delete();
            mT.delete();
            mValid <= 1'b0;
        end else begin
            mCycle = mCycle + 1;
            if (dutValidIn && dutReadyOut && mQ.size() > 0) begin
                void'(mQ.pop_front());
                void'(mT.pop_front());
            end
            if (dutValidOut && dutReadyIn) begin
                mQ.push_back(dutDataOut);
                mT.push_back(mCycle);
            end
            if (mQ.size() > 0) begin
                mData  <= mQ[0];
                mValid <= mOutEn && ((mCycle - mT[0]) >= LAT);
            end else begin
                mValid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (rspValid[c] && rspReady[c]) begin
                obsQ.push_back({16'(c), rspData});
            end
        end
    end

    always @(negedge clk) begin
        if (peakClear) begin
            peakOut <= '0;
        end else if (outstanding > peakOut) begin
            peakOut <= outstanding;
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic resetDut();
        resetN    = 1'b0;
        reqValid  = '0;
        tbForce   = 1'b0;
        mOutEn    = 1'b1;
        dutReadyIn = 1'b1;
        rspReady  = '1;
        peakClear = 1'b1;
        repeat (2) @(negedge clk);
        expQ.delete();
        obsQ.delete();
        resetN    = 1'b1;
        peakClear = 1'b0;
    endtask

    // Offer one word on a channel until accepted, then leave one idle cycle.
    task automatic applyStimulus(input int ch, input logic [WD-1:0] d);
        bit done = 1'b0;
        reqData[ch*WD +: WD] = d;
        reqValid[ch] = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (reqReady[ch]) begin
                expQ.push_back({16'(ch), d});
                done = 1'b1;
                @(negedge clk);
                reqValid[ch] = 1'b0;
                checkEq("issue_data", 32'(dutDataOut), 32'(d));
                checkEq("issue_valid", 32'(dutValidOut), 32'd1);
            end else begin
                @(negedge clk);
            end
        end
        checkEq("accept_timeout", 32'(done), 32'd1);
        @(negedge clk);
    endtask

    task automatic waitDrain(input string tag);
        for (int k = 0; k < 100 && outstanding != 0; k++) @(negedge clk);
        checkEq(tag, 32'(outstanding), 32'd0);
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] e;
        logic [31:0] o;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = (obsQ.size() > 0) ? obsQ.pop_front() : 32'hFFFF_FFFF;
            checkEq(tag, o, e);
        end
        checkEq({tag, "_extra"}, 32'(obsQ.size()), 32'd0);
    endtask

    initial begin
        int n;
        int grants;
        int expCh;
        int idx0;
        int idx1;
        bit seen;

        $display("[TB] start");
        #1 resetN = 1'b0;
        reqValid = 2'b11;
        #1;
        checkEq("rst_req_ready", 32'(reqReady), 32'd0);
        checkEq("rst_dut_valid", 32'(dutValidOut), 32'd0);
        checkEq("rst_dut_data", 32'(dutDataOut), 32'd0);
        checkEq("rst_outstanding", 32'(outstanding), 32'd0);
        checkEq("rst_err", 32'(errFlag), 32'd0);
        checkEq("rst_rsp_valid", 32'(rspValid), 32'd0);

        // Single channel, three spaced vectors.
        @(negedge clk);
        resetDut();
        applyStimulus(0, 16'h0011);
        applyStimulus(0, 16'h0022);
        applyStimulus(0, 16'h0033);
        waitDrain("t1_drain");
        checkEq("t1_peak", 32'(peakOut), 32'd2);
        checkOutput("t1_rsp");

        // Both channels continuously valid: grants alternate from channel 0.
        resetDut();
        idx0 = 0;
        idx1 = 0;
        grants = 0;
        expCh = 0;
        reqData = {16'hB000, 16'hA000};
        reqValid = 2'b11;
        for (int cyc = 0; cyc < 100 && grants < 8; cyc++) begin
            #1;
            if (reqReady != '0) begin
                checkEq("t2_grant", 32'(reqReady), (expCh == 0) ? 32'd1 : 32'd2);
                if (expCh == 0) begin
                    expQ.push_back({16'd0, 16'hA000 + 16'(idx0)});
                    idx0++;
                end else begin
                    expQ.push_back({16'd1, 16'hB000 + 16'(idx1)});
                    idx1++;
                end
                expCh = 1 - expCh;
                grants++;
            end
            @(negedge clk);
            reqData = {16'hB000 + 16'(idx1), 16'hA000 + 16'(idx0)};
        end
        reqValid = '0;
        checkEq("t2_grant_count", 32'(grants), 32'd8);
        waitDrain("t2_drain");
        checkOutput("t2_rsp");

        // DUT output held off: fill to the limit, release exactly one response.
        resetDut();
        mOutEn = 1'b0;
        n = 0;
        reqData[WD-1:0] = 16'hC000;
        reqValid = 2'b01;
        for (int cyc = 0; cyc < 50 && n < 4; cyc++) begin
            #1;
            if (reqReady[0]) begin
                expQ.push_back({16'd0, 16'hC000 + 16'(n)});
                n++;
            end
            @(negedge clk);
            reqData[WD-1:0] = 16'hC000 + 16'(n);
        end
        checkEq("t3_accepts", 32'(n), 32'd4);
        #1;
        checkEq("t3_full_count", 32'(outstanding), 32'd4);
        checkEq("t3_full_ready", 32'(reqReady), 32'd0);
        @(negedge clk);
        #1;
        checkEq("t3_full_ready_hold", 32'(reqReady), 32'd0);
        tbForce = 1'b1;
        @(negedge clk);
        tbForce = 1'b0;
        #1;
        checkEq("t3_one_grant", 32'(reqReady), 32'd1);
        checkEq("t3_count_after_pop", 32'(outstanding), 32'd3);
        expQ.push_back({16'd0, 16'hC004});
        @(negedge clk);
        #1;
        checkEq("t3_refull_ready", 32'(reqReady), 32'd0);
        checkEq("t3_refull_count", 32'(outstanding), 32'd4);
        reqValid = '0;
        mOutEn = 1'b1;
        waitDrain("t3_drain");
        checkOutput("t3_rsp");

        // DUT input stalled for five cycles.
        resetDut();
        dutReadyIn = 1'b0;
        reqData[2*WD-1:WD] = 16'hD001;
        reqValid = 2'b10;
        #1;
        checkEq("t4_first_grant", 32'(reqReady), 32'd2);
        expQ.push_back({16'd1, 16'hD001});
        @(negedge clk);
        reqData[2*WD-1:WD] = 16'hD002;
        for (int k = 0; k < 5; k++) begin
            #1;
            checkEq("t4_stall_data", 32'(dutDataOut), 32'h0000_D001);
            checkEq("t4_stall_ready", 32'(reqReady), 32'd0);
            @(negedge clk);
        end
        dutReadyIn = 1'b1;
        #1;
        checkEq("t4_regrant", 32'(reqReady), 32'd2);
        expQ.push_back({16'd1, 16'hD002});
        @(negedge clk);
        reqValid = '0;
        checkEq("t4_next_data", 32'(dutDataOut), 32'h0000_D002);
        waitDrain("t4_drain");
        checkOutput("t4_rsp");

        // Head-of-line: channel 1 at the head refuses its response.
        resetDut();
        rspReady = 2'b01;
        applyStimulus(1, 16'hE001);
        applyStimulus(0, 16'hE000);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (dutValidIn) seen = 1'b1;
            else @(negedge clk);
        end
        checkEq("t5_head_present", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        checkEq("t5_rsp_valid", 32'(rspValid), 32'd2);
        checkEq("t5_dut_ready", 32'(dutReadyOut), 32'd0);
        checkEq("t5_outstanding", 32'(outstanding), 32'd2);
        checkEq("t5_no_rsp", 32'(obsQ.size()), 32'd0);
        rspReady = 2'b11;
        waitDrain("t5_drain");
        checkOutput("t5_rsp");

        // DUT output with nothing outstanding.
        resetDut();
        tbForce = 1'b1;
        #1;
        checkEq("t6_empty_ready", 32'(dutReadyOut), 32'd0);
        checkEq("t6_empty_rsp", 32'(rspValid), 32'd0);
        @(negedge clk);
        tbForce = 1'b0;
        checkEq("t6_err_set", 32'(errFlag), 32'd1);
        repeat (3) @(negedge clk);
        checkEq("t6_err_sticky", 32'(errFlag), 32'd1);

        // Reset mid-burst with three outstanding.
        mOutEn = 1'b0;
        n = 0;
        reqData[WD-1:0] = 16'hF000;
        reqValid = 2'b01;
        for (int cyc = 0; cyc < 50 && n < 3; cyc++) begin
            #1;
            if (reqReady[0]) n++;
            @(negedge clk);
            reqData[WD-1:0] = 16'hF000 + 16'(n);
        end
        reqValid = 2'b00;
        #1;
        checkEq("t7_outstanding", 32'(outstanding), 32'd3);
        checkEq("t7_err_before", 32'(errFlag), 32'd1);
        reqValid = 2'b11;
        #1;
        resetN = 1'b0;
        #1;
        checkEq("t7_rst_outstanding", 32'(outstanding), 32'd0);
        checkEq("t7_rst_dut_valid", 32'(dutValidOut), 32'd0);
        checkEq("t7_rst_dut_data", 32'(dutDataOut), 32'd0);
        checkEq("t7_rst_req_ready", 32'(reqReady), 32'd0);
        checkEq("t7_rst_rsp_valid", 32'(rspValid), 32'd0);
        checkEq("t7_rst_err", 32'(errFlag), 32'd0);
        expQ.delete();
        obsQ.delete();
        @(negedge clk);
        resetN = 1'b1;
        mOutEn = 1'b1;
        #1;
        checkEq("t7_rr_zero", 32'(reqReady), 32'd1);
        reqValid = '0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
